// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
// Holds the FSM state encodings, the frame data width, the default bit
// period and the even-parity helper used when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 87;
    localparam int UART_TIMER_W              = 9;

    function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous first-word fall-through FIFO that queues bytes
// waiting for the transmitter. dout always shows the head entry; a push
// while full and a pop while empty are ignored. full is kept as a register
// so the transmitter's ready output comes straight from a flop.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] din,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] dout,
    output logic [FIFO_AW:0]          count,
    output logic                      full,
    output logic                      empty
);

    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    logic [UART_DATA_BITS-1:0] mem_q [2**FIFO_AW];
    logic [FIFO_AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]          count_q, count_d;
    logic                      full_q, full_d;
    logic                      push_ok, pop_ok;

    assign push_ok = push & ~full_q;
    assign pop_ok  = pop & (count_q != '0);

    // Next pointers and occupancy; pointers wrap naturally at 2**FIFO_AW.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == DEPTH);
    end

    // Control state: pointers, occupancy and the registered full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage array; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered 8N1 UART transmitter (LSB first) returning
// decrypted bytes from the RSA core to the host. Bytes are queued in
// uart_tx_fifo and sent back to back with one idle-high clock between
// frames. Define UART_TX_PARITY_EN to insert an even-parity bit after D7;
// the receiver must be built with the same setting.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_AW      = 2
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Tx_DV,
    input  logic [7:0]       i_Tx_Byte,
    output logic             o_Tx_Ready,
    output logic             o_Tx_Overflow,
    output logic             o_Tx_Serial,
    output logic             o_Tx_Active,
    output logic             o_Tx_Done,
    output logic [FIFO_AW:0] o_Fifo_Count
);

    localparam logic [UART_TIMER_W-1:0] BIT_LAST = UART_TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]              IDX_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_e               state_q, state_d;
    logic [UART_TIMER_W-1:0]   timer_q, timer_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      serial_q, serial_d;
    logic                      active_q, active_d;
    logic                      done_q, done_d;
    logic                      ovf_q, ovf_d;

    logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      bit_end;

    // A write is accepted only while not full; a full-time write is dropped
    // and flagged, even when the FSM pops in the same cycle.
    assign fifo_push = i_Tx_DV & ~fifo_full;
    assign ovf_d     = i_Tx_DV & fifo_full;
    assign bit_end   = (timer_q == BIT_LAST);

    uart_tx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (i_Clock),
        .rst   (i_Reset),
        .push  (fifo_push),
        .din   (i_Tx_Byte),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (o_Fifo_Count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next state, bit timer/index, pop request and the registered line values.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                idx_d   = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = ST_DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = ST_STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                timer_d = '0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // The line is registered from the state being entered, so the start
        // bit appears right after the pop edge.
        case (state_d)
            ST_START: serial_d = 1'b0;
            ST_DATA:  serial_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: serial_d = uart_even_parity(shift_d);
`endif
            default:  serial_d = 1'b1;
        endcase
        active_d = (state_d != ST_IDLE);
    end

    // Control and output registers; reset aborts any frame in flight.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    // Shift register holds the frame's byte; only loaded on a pop.
    always_ff @(posedge i_Clock) begin
        shift_q <= shift_d;
    end

    assign o_Tx_Ready    = ~fifo_full;
    assign o_Tx_Overflow = ovf_q;
    assign o_Tx_Serial   = serial_q;
    assign o_Tx_Active   = active_q;
    assign o_Tx_Done     = done_q;

endmodule
